servo_pwm_capture: RTL



---
 rtl/servo_pwm_capture.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/servo_pwm_capture.sv
// Servo PWM capture: measures the high time and rise-to-rise period of pwm_in in
// microseconds and publishes each completed period with a one-cycle valid strobe.
module servo_pwm_capture #(
  parameter int unsigned CLKS_PER_US = 100,
  parameter int unsigned MIN_US      = 500,
  parameter int unsigned MAX_US      = 2500,
  parameter int unsigned TIMEOUT_US  = 25000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pwm_in,
  output logic [15:0] high_us,
  output logic [15:0] period_us,
  output logic        valid,
  output logic        in_range,
  output logic        signal_lost
);

  localparam int unsigned PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(CLKS_PER_US - 1);
  localparam logic [15:0]   TIMEOUT_V = 16'(TIMEOUT_US);
  localparam logic [15:0]   MIN_V     = 16'(MIN_US);
  localparam logic [15:0]   MAX_V     = 16'(MAX_US);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, prev_q;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0] hi_cnt_q, hi_cnt_d, per_cnt_q, per_cnt_d;
  logic [15:0] high_us_q, high_us_d, period_us_q, period_us_d;
  logic        valid_q, valid_d, in_range_q, in_range_d, lost_q, lost_d;
  logic        rise, fall, us_tick;
  logic [15:0] hi_inc, per_inc;

  // Chain resets to 1 so a line already high at reset exit never looks like a rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise    = sync2_q & ~prev_q;
  assign fall    = ~sync2_q & prev_q;
  assign us_tick = (pre_q == PRE_LAST);
  assign hi_inc  = (us_tick && (hi_cnt_q != '1)) ? hi_cnt_q + 16'd1 : hi_cnt_q;
  assign per_inc = (us_tick && (per_cnt_q != '1)) ? per_cnt_q + 16'd1 : per_cnt_q;

  always_comb begin
    pre_d = pre_q + PW'(1);
    if (rise || us_tick) pre_d = '0;
  end

  // Loaded period includes a tick landing on the rise cycle, giving floor(clks/CLKS_PER_US).
  always_comb begin
    state_d     = state_q;
    hi_cnt_d    = hi_cnt_q;
    per_cnt_d   = per_cnt_q;
    high_us_d   = high_us_q;
    period_us_d = period_us_q;
    in_range_d  = in_range_q;
    valid_d     = 1'b0;
    lost_d      = lost_q;
    case (state_q)
      IDLE: begin
        hi_cnt_d  = '0;
        per_cnt_d = '0;
        if (rise) state_d = HIGH;
      end
      HIGH: begin
        hi_cnt_d  = hi_inc;
        per_cnt_d = per_inc;
        if (per_cnt_q == TIMEOUT_V) begin
          state_d   = IDLE;
          lost_d    = 1'b1;
          hi_cnt_d  = '0;
          per_cnt_d = '0;
        end else if (fall) begin
          state_d = LOW;
        end
      end
      LOW: begin
        per_cnt_d = per_inc;
        if (rise) begin
          high_us_d   = hi_cnt_q;
          period_us_d = per_inc;
          in_range_d  = (hi_cnt_q >= MIN_V) && (hi_cnt_q <= MAX_V);
          valid_d     = 1'b1;
          lost_d      = 1'b0;
          hi_cnt_d    = '0;
          per_cnt_d   = '0;
          state_d     = HIGH;
        end else if (per_cnt_q == TIMEOUT_V) begin
          state_d   = IDLE;
          lost_d    = 1'b1;
          hi_cnt_d  = '0;
          per_cnt_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        hi_cnt_d  = '0;
        per_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pre_q       <= '0;
      hi_cnt_q    <= '0;
      per_cnt_q   <= '0;
      high_us_q   <= '0;
      period_us_q <= '0;
      in_range_q  <= 1'b0;
      valid_q     <= 1'b0;
      lost_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      hi_cnt_q    <= hi_cnt_d;
      per_cnt_q   <= per_cnt_d;
      high_us_q   <= high_us_d;
      period_us_q <= period_us_d;
      in_range_q  <= in_range_d;
      valid_q     <= valid_d;
      lost_q      <= lost_d;
    end
  end

  assign high_us     = high_us_q;
  assign period_us   = period_us_q;
  assign valid       = valid_q;
  assign in_range    = in_range_q;
  assign signal_lost = lost_q;

endmodule
